// File: rtl/kp_pkg.sv
// Shared keypoint types and widths used by the feature pipeline, keypoint buffer and matcher.
package kp_pkg;

    localparam int KP_COOR_W  = 10;
    localparam int KP_SCORE_W = 8;
    localparam int KP_DESC_W  = 256;

    typedef struct packed {
        logic [KP_COOR_W-1:0]  x;
        logic [KP_COOR_W-1:0]  y;
        logic [KP_SCORE_W-1:0] score;
        logic [KP_DESC_W-1:0]  desc;
    } keypoint_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FLUSH,
        DRAIN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/key_buffer_ctrl.sv
// Frame-level sequencer: admits scored keypoints into the keypoint buffer during a frame,
// then drains them in arrival order to the matcher and pulses completion.
module key_buffer_ctrl
    import kp_pkg::*;
#(
    parameter int                    SIZE     = 10,
    parameter logic [KP_SCORE_W-1:0] SCORE_TH = 8'd0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_frame_start,
    input  logic                  i_frame_end,
    input  logic                  i_kp_valid,
    output logic                  o_kp_ready,
    input  logic [KP_COOR_W-1:0]  i_kp_coor_x,
    input  logic [KP_COOR_W-1:0]  i_kp_coor_y,
    input  logic [KP_SCORE_W-1:0] i_kp_score,
    input  logic [KP_DESC_W-1:0]  i_kp_desc,
    output logic                  o_buf_valid,
    output logic                  o_buf_next,
    output logic [KP_COOR_W-1:0]  o_buf_coor_x,
    output logic [KP_COOR_W-1:0]  o_buf_coor_y,
    output logic [KP_SCORE_W-1:0] o_buf_score,
    output logic [KP_DESC_W-1:0]  o_buf_desc,
    input  logic [KP_COOR_W-1:0]  i_buf_coor_x,
    input  logic [KP_COOR_W-1:0]  i_buf_coor_y,
    input  logic [KP_SCORE_W-1:0] i_buf_score,
    input  logic [KP_DESC_W-1:0]  i_buf_desc,
    output logic                  o_match_valid,
    input  logic                  i_match_ready,
    output logic [KP_COOR_W-1:0]  o_match_coor_x,
    output logic [KP_COOR_W-1:0]  o_match_coor_y,
    output logic [KP_SCORE_W-1:0] o_match_score,
    output logic [KP_DESC_W-1:0]  o_match_desc,
    output logic                  o_match_last,
    output logic                  o_frame_done,
    output logic [9:0]            o_kp_count,
    output logic [9:0]            o_drop_count,
    output logic                  o_overrun
);

    localparam logic [9:0] SIZE_C   = 10'(SIZE);
    localparam logic [9:0] DROP_MAX = 10'd1023;

    ctrl_state_t           r_state;
    ctrl_state_t           w_next;
    logic                  r_buf_valid;
    logic [KP_COOR_W-1:0]  r_buf_coor_x;
    logic [KP_COOR_W-1:0]  r_buf_coor_y;
    logic [KP_SCORE_W-1:0] r_buf_score;
    logic [KP_DESC_W-1:0]  r_buf_desc;
    logic [9:0]            r_kp_count;
    logic [9:0]            r_drop_count;
    logic [9:0]            r_remaining;
    logic                  r_overrun;

    logic w_in_fill;
    logic w_admit;
    logic w_drop;
    logic w_handshake;

    assign w_in_fill   = (r_state == FILL);
    assign w_admit     = w_in_fill && i_kp_valid && (i_kp_score >= SCORE_TH) && (r_kp_count < SIZE_C);
    assign w_drop      = w_in_fill && i_kp_valid && !w_admit;
    assign w_handshake = (r_state == DRAIN) && i_match_ready;

    // Drain payload is gated by state so every output reads zero outside DRAIN, including under reset.
    always_comb begin
        w_next         = r_state;
        o_kp_ready     = 1'b0;
        o_match_valid  = 1'b0;
        o_match_last   = 1'b0;
        o_buf_next     = 1'b0;
        o_frame_done   = 1'b0;
        o_match_coor_x = '0;
        o_match_coor_y = '0;
        o_match_score  = '0;
        o_match_desc   = '0;

        unique case (r_state)
            IDLE: begin
                if (i_frame_start) w_next = FILL;
            end
            FILL: begin
                o_kp_ready = 1'b1;
                if (i_frame_end) w_next = FLUSH;
            end
            FLUSH: begin
                w_next = (r_kp_count != 10'd0) ? DRAIN : DONE;
            end
            DRAIN: begin
                o_match_valid  = 1'b1;
                o_match_coor_x = i_buf_coor_x;
                o_match_coor_y = i_buf_coor_y;
                o_match_score  = i_buf_score;
                o_match_desc   = i_buf_desc;
                o_match_last   = (r_remaining == 10'd1);
                o_buf_next     = i_match_ready;
                if (w_handshake && (r_remaining == 10'd1)) w_next = DONE;
            end
            DONE: begin
                o_frame_done = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_buf_valid  <= 1'b0;
            r_buf_coor_x <= '0;
            r_buf_coor_y <= '0;
            r_buf_score  <= '0;
            r_buf_desc   <= '0;
            r_kp_count   <= '0;
            r_drop_count <= '0;
            r_remaining  <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_buf_valid <= w_admit;
            if (w_admit) begin
                r_buf_coor_x <= i_kp_coor_x;
                r_buf_coor_y <= i_kp_coor_y;
                r_buf_score  <= i_kp_score;
                r_buf_desc   <= i_kp_desc;
            end

            // Counters are only cleared by a new frame so they stay readable after DONE.
            if ((r_state == IDLE) && i_frame_start) begin
                r_kp_count   <= '0;
                r_drop_count <= '0;
            end else begin
                if (w_admit) r_kp_count <= r_kp_count + 10'd1;
                if (w_drop && (r_drop_count != DROP_MAX)) r_drop_count <= r_drop_count + 10'd1;
            end

            if (i_frame_start && (r_state != IDLE)) r_overrun <= 1'b1;

            if (r_state == FLUSH) r_remaining <= r_kp_count;
            else if (w_handshake) r_remaining <= r_remaining - 10'd1;
        end
    end

    assign o_buf_valid  = r_buf_valid;
    assign o_buf_coor_x = r_buf_coor_x;
    assign o_buf_coor_y = r_buf_coor_y;
    assign o_buf_score  = r_buf_score;
    assign o_buf_desc   = r_buf_desc;
    assign o_kp_count   = r_kp_count;
    assign o_drop_count = r_drop_count;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_key_buffer_ctrl.sv
// Randomized self-checking bench for key_buffer_ctrl against a queue-based frame model and a behavioural buffer.
module tb_key_buffer_ctrl;
    import kp_pkg::*;

    localparam int         SIZE     = 10;
    localparam logic [7:0] SCORE_TH = 8'd8;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_frame_start = 1'b0;
    logic         i_frame_end = 1'b0;
    logic         i_kp_valid = 1'b0;
    logic         o_kp_ready;
    logic [9:0]   i_kp_coor_x = '0;
    logic [9:0]   i_kp_coor_y = '0;
    logic [7:0]   i_kp_score = '0;
    logic [255:0] i_kp_desc = '0;
    logic         o_buf_valid;
    logic         o_buf_next;
    logic [9:0]   o_buf_coor_x;
    logic [9:0]   o_buf_coor_y;
    logic [7:0]   o_buf_score;
    logic [255:0] o_buf_desc;
    logic [9:0]   i_buf_coor_x = '0;
    logic [9:0]   i_buf_coor_y = '0;
    logic [7:0]   i_buf_score = '0;
    logic [255:0] i_buf_desc = '0;
    logic         o_match_valid;
    logic         i_match_ready = 1'b0;
    logic [9:0]   o_match_coor_x;
    logic [9:0]   o_match_coor_y;
    logic [7:0]   o_match_score;
    logic [255:0] o_match_desc;
    logic         o_match_last;
    logic         o_frame_done;
    logic [9:0]   o_kp_count;
    logic [9:0]   o_drop_count;
    logic         o_overrun;

    always #5 i_clk = ~i_clk;

    key_buffer_ctrl #(.SIZE(SIZE), .SCORE_TH(SCORE_TH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
        .i_kp_valid(i_kp_valid), .o_kp_ready(o_kp_ready),
        .i_kp_coor_x(i_kp_coor_x), .i_kp_coor_y(i_kp_coor_y),
        .i_kp_score(i_kp_score), .i_kp_desc(i_kp_desc),
        .o_buf_valid(o_buf_valid), .o_buf_next(o_buf_next),
        .o_buf_coor_x(o_buf_coor_x), .o_buf_coor_y(o_buf_coor_y),
        .o_buf_score(o_buf_score), .o_buf_desc(o_buf_desc),
        .i_buf_coor_x(i_buf_coor_x), .i_buf_coor_y(i_buf_coor_y),
        .i_buf_score(i_buf_score), .i_buf_desc(i_buf_desc),
        .o_match_valid(o_match_valid), .i_match_ready(i_match_ready),
        .o_match_coor_x(o_match_coor_x), .o_match_coor_y(o_match_coor_y),
        .o_match_score(o_match_score), .o_match_desc(o_match_desc),
        .o_match_last(o_match_last), .o_frame_done(o_frame_done),
        .o_kp_count(o_kp_count), .o_drop_count(o_drop_count),
        .o_overrun(o_overrun)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level reference: what should be admitted and how the counters should end up.
    keypoint_t expQ[$];
    int        expKp;
    int        expDrop;
    bit        expOverrun = 1'b0;

    // Behavioural keypoint buffer: FIFO with the head presented combinationally.
    keypoint_t bufQ[$];
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bufQ.delete();
        end else begin
            if (o_buf_valid) bufQ.push_back({o_buf_coor_x, o_buf_coor_y, o_buf_score, o_buf_desc});
            if (o_buf_next && bufQ.size() > 0) void'(bufQ.pop_front());
        end
        if (bufQ.size() > 0) {i_buf_coor_x, i_buf_coor_y, i_buf_score, i_buf_desc} = bufQ[0];
        else {i_buf_coor_x, i_buf_coor_y, i_buf_score, i_buf_desc} = '0;
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_kp_ready"}, o_kp_ready, 0);
        checkOutput({tag, "_buf_valid"}, o_buf_valid, 0);
        checkOutput({tag, "_buf_next"}, o_buf_next, 0);
        checkOutput({tag, "_buf_payload"}, {o_buf_coor_x, o_buf_coor_y, o_buf_score, o_buf_desc}, 0);
        checkOutput({tag, "_match_valid"}, o_match_valid, 0);
        checkOutput({tag, "_match_payload"}, {o_match_coor_x, o_match_coor_y, o_match_score, o_match_desc}, 0);
        checkOutput({tag, "_match_last"}, o_match_last, 0);
        checkOutput({tag, "_frame_done"}, o_frame_done, 0);
        checkOutput({tag, "_kp_count"}, o_kp_count, 0);
        checkOutput({tag, "_drop_count"}, o_drop_count, 0);
        checkOutput({tag, "_overrun"}, o_overrun, 0);
    endtask

    // readyMode: 0 = always ready, 1 = toggle 1010..., 2 = random.
    task automatic applyStimulus(input int nCand, input int scores[$], input int readyMode,
                                 input bit endWithLast, input bit overrunInDrain, input bit resetInDrain);
        keypoint_t kp;
        keypoint_t prevKp;
        keypoint_t got;
        keypoint_t held;
        bit        prevAdmit;
        bit        stalled;
        bit        toggle;
        bit        rdy;
        int        cyc;

        expQ.delete();
        expKp     = 0;
        expDrop   = 0;
        prevAdmit = 1'b0;
        prevKp    = '0;
        held      = '0;

        i_frame_start = 1'b1;
        nextCycle();
        i_frame_start = 1'b0;

        for (int i = 0; i < nCand; i++) begin
            kp.x     = 10'($urandom);
            kp.y     = 10'($urandom);
            kp.score = (scores.size() > i) ? 8'(scores[i]) : 8'($urandom_range(0, 255));
            kp.desc  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            {i_kp_coor_x, i_kp_coor_y, i_kp_score, i_kp_desc} = kp;
            i_kp_valid  = 1'b1;
            i_frame_end = endWithLast && (i == nCand - 1);
            #1;
            checkOutput("kp_ready_fill", o_kp_ready, 1);
            checkOutput("buf_valid_fill", o_buf_valid, prevAdmit);
            if (prevAdmit)
                checkOutput("buf_payload", {o_buf_coor_x, o_buf_coor_y, o_buf_score, o_buf_desc}, prevKp);
            if (kp.score >= SCORE_TH && expKp < SIZE) begin
                expQ.push_back(kp);
                expKp++;
                prevAdmit = 1'b1;
                prevKp    = kp;
            end else begin
                prevAdmit = 1'b0;
                if (expDrop < 1023) expDrop++;
            end
            nextCycle();
        end
        i_kp_valid = 1'b0;

        if (!endWithLast || nCand == 0) begin
            i_frame_end = 1'b1;
            #1;
            checkOutput("buf_valid_end", o_buf_valid, prevAdmit);
            prevAdmit = 1'b0;
            nextCycle();
        end
        i_frame_end = 1'b0;

        // FLUSH cycle: last insert lands, nothing offered to the matcher yet.
        #1;
        checkOutput("buf_valid_flush", o_buf_valid, prevAdmit);
        checkOutput("match_valid_flush", o_match_valid, 0);
        checkOutput("frame_done_flush", o_frame_done, 0);
        checkOutput("kp_ready_flush", o_kp_ready, 0);
        checkOutput("kp_count_flush", o_kp_count, expKp);
        nextCycle();

        stalled = 1'b0;
        toggle  = 1'b1;
        cyc     = 0;
        while (expQ.size() > 0 && cyc < 4 * SIZE + 20) begin
            case (readyMode)
                0:       rdy = 1'b1;
                1:       begin rdy = toggle; toggle = ~toggle; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_match_ready = rdy;
            i_frame_start = overrunInDrain && (cyc == 1);
            if (overrunInDrain && cyc == 1) expOverrun = 1'b1;
            #1;
            got = {o_match_coor_x, o_match_coor_y, o_match_score, o_match_desc};
            checkOutput("match_valid_drain", o_match_valid, 1);
            checkOutput("match_last", o_match_last, expQ.size() == 1);
            checkOutput("buf_next", o_buf_next, rdy);
            checkOutput("buf_valid_drain", o_buf_valid, 0);
            checkOutput("kp_ready_drain", o_kp_ready, 0);
            if (stalled) checkOutput("match_stable", got, held);
            if (rdy) begin
                checkOutput("match_data", got, expQ.pop_front());
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = got;
            end
            if (resetInDrain && cyc == 2) begin
                #1;
                i_rst_n = 1'b0;
                #1;
                checkAllZero("rst_drain");
                expOverrun    = 1'b0;
                i_match_ready = 1'b0;
                i_frame_start = 1'b0;
                nextCycle();
                i_rst_n = 1'b1;
                nextCycle();
                return;
            end
            nextCycle();
            cyc++;
        end
        i_match_ready = 1'b0;
        i_frame_start = 1'b0;
        if (expQ.size() > 0) checkOutput("drain_timeout", 1, 0);

        #1;
        checkOutput("frame_done", o_frame_done, 1);
        checkOutput("match_valid_done", o_match_valid, 0);
        checkOutput("kp_count_done", o_kp_count, expKp);
        checkOutput("drop_count_done", o_drop_count, expDrop);
        checkOutput("overrun", o_overrun, expOverrun);
        nextCycle();
        checkOutput("frame_done_pulse", o_frame_done, 0);
        checkOutput("kp_count_hold", o_kp_count, expKp);
        checkOutput("buf_empty_after_drain", bufQ.size(), 0);
    endtask

    int noScores[$];

    initial begin
        noScores = {};
        nextCycle();
        checkAllZero("reset");
        i_rst_n = 1'b1;
        nextCycle();

        applyStimulus(3, '{15, 9, 27}, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(14, noScores, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, '{3, 8, 12}, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(6, noScores, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, noScores, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5, '{50, 60, 70, 80, 90}, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4, noScores, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(4, '{40, 41, 42, 43}, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, '{100, 200}, 0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 8; f++)
            applyStimulus($urandom_range(0, 14), noScores, 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        applyStimulus(1040, noScores, 2, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
